byte_arbiter: RTL

- Upstream feeder for the team's 8-bit 2:1 Mux.
- Buffers two independent 8-bit byte streams, each in its own small FIFO.
- Arbitrates between them round-robin and drives the Mux select (s) plus both data legs (a = channel 0 head, b = channel 1 head).
- Registers the Mux output into a valid/ready output stage with a source tag.

---
 rtl/byte_arbiter_pkg.sv | 10 +
 rtl/byte_fifo.sv | 52 +++++
 rtl/mux8.sv | 14 +
 rtl/byte_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/byte_arbiter_pkg.sv
// Shared constants for the byte arbiter slice.
// Data width and channel encodings used across the datapath.
package byte_arbiter_pkg;

    localparam int DATA_W = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Small per-channel byte FIFO with a registered count.
// No write-through: a full FIFO refuses a push even if it pops.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    assign ready = (count < (AW+1)'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mux8.sv
// 8-bit 2:1 mux shared by the byte datapath.
// s = 0 selects a, s = 1 selects b.
module mux8
    import byte_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              s,
    output logic [DATA_W-1:0] out
);

    assign out = s ? b : a;

endmodule

// File: rtl/byte_arbiter.sv
// Two-channel round-robin byte arbiter feeding the 8-bit mux,
// with a bubble-free valid/ready output register and source tag.
module byte_arbiter
    import byte_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src
);

    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] head1;
    logic [WIDTH-1:0] mux_out;
    logic             empty0;
    logic             empty1;
    logic             pop0;
    logic             pop1;
    logic             load;
    logic             gnt_any;
    logic             gnt;
    logic             last_grant;

    byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (in0_valid && in0_ready),
        .wdata (in0_data),
        .pop   (pop0),
        .rdata (head0),
        .empty (empty0),
        .ready (in0_ready)
    );

    byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (in1_valid && in1_ready),
        .wdata (in1_data),
        .pop   (pop1),
        .rdata (head1),
        .empty (empty1),
        .ready (in1_ready)
    );

    assign load = !out_valid || out_ready;

    // With no request the select parks on last_grant, keeping s defined.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = last_grant;
        unique case (1'b1)
            (!empty0 && !empty1): begin
                gnt_any = 1'b1;
                gnt     = ~last_grant;
            end
            (!empty0 && empty1): begin
                gnt_any = 1'b1;
                gnt     = CH0;
            end
            (empty0 && !empty1): begin
                gnt_any = 1'b1;
                gnt     = CH1;
            end
            default: begin
                gnt_any = 1'b0;
                gnt     = last_grant;
            end
        endcase
    end

    assign pop0 = load && gnt_any && (gnt == CH0);
    assign pop1 = load && gnt_any && (gnt == CH1);

    mux8 u_mux (
        .a   (head0),
        .b   (head1),
        .s   (gnt),
        .out (mux_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= CH0;
            last_grant <= CH1;
        end else if (load) begin
            if (gnt_any) begin
                out_valid  <= 1'b1;
                out_data   <= mux_out;
                out_src    <= gnt;
                last_grant <= gnt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
